// File: rtl/mem_addr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mem_addr_sequencer_pkg
//
// Purpose:
//   Shared definitions for the memory address sequencer:
//     - address source index constants (datapath order of the sources)
//     - sequencer state encoding
//     - small helper for the word-alignment check
//
// No ports (package).
// ---------------------------------------------------------------------------
package mem_addr_sequencer_pkg;

    // Address source indices as wired on the flattened src_addr bus.
    localparam int SRC_PC     = 0;  // program counter
    localparam int SRC_EXC    = 1;  // exception vector address
    localparam int SRC_ALUOUT = 2;  // registered ALU output
    localparam int SRC_ALURES = 3;  // combinational ALU result
    localparam int SRC_SWAP1  = 4;  // swap temp address 1 (beat 0)
    localparam int SRC_SWAP2  = 5;  // swap temp address 2 (beat 1)

    // Sequencer state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // A word access needs the two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage : mem_addr_sequencer_pkg

// File: rtl/mem_addr_sequencer_addr_src_select.sv
// ---------------------------------------------------------------------------
// addr_src_select
//
// Purpose:
//   Purely combinational indexed select over a flattened bus of NUM_SRC
//   address sources. Source i occupies src_addr[i*ADDR_W +: ADDR_W].
//   An index at or beyond NUM_SRC raises out_of_range and returns zero,
//   so the consumer never sees X from a non-existent source.
//
// Ports:
//   src_addr      in   NUM_SRC*ADDR_W  flattened address sources
//   idx           in   SEL_W           source index
//   addr          out  ADDR_W          selected source (0 when out of range)
//   out_of_range  out  1               idx >= NUM_SRC
// ---------------------------------------------------------------------------
module addr_src_select #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [SEL_W-1:0]          idx,
    output logic [ADDR_W-1:0]         addr,
    output logic                      out_of_range
);

    // One extra bit so NUM_SRC == 2^SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

    always_comb begin
        out_of_range = ({1'b0, idx} >= NUM_SRC_W);
    end

    // Compare-and-pick loop rather than a variable part-select so an
    // out-of-range index simply matches nothing.
    always_comb begin
        addr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == SEL_W'(i)) begin
                addr = src_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule : addr_src_select

// File: rtl/mem_addr_sequencer.sv
// ---------------------------------------------------------------------------
// mem_addr_sequencer
//
// Purpose:
//   Registered memory-address select. Picks one of NUM_SRC address sources,
//   registers it onto mem_addr and runs a req/ack handshake to memory. A
//   swap access is sequenced as two beats (SWAP_A_IDX then SWAP_B_IDX)
//   without further help from the control unit. Illegal selects and
//   misaligned word addresses are reported as one-cycle error pulses so the
//   control unit can take the exception path.
//
// Handshake:
//   mem_req is raised with a stable mem_addr and held, together with
//   mem_addr, until memory answers with mem_ack in a cycle where mem_req is
//   high; the beat completes in that cycle. mem_ack while mem_req is low is
//   ignored.
//
// Ports:
//   clk              in   1               system clock, rising edge
//   reset_n          in   1               synchronous active-low reset
//   start            in   1               one-cycle access request (IDLE only)
//   sel              in   SEL_W           source index, single access
//   swap_mode        in   1               1 = two-beat swap sequence
//   word_access      in   1               1 = check word alignment
//   src_addr         in   NUM_SRC*ADDR_W  flattened address sources
//   mem_ack          in   1               memory accepted current beat
//   mem_addr         out  ADDR_W          registered address to memory
//   mem_req          out  1               beat request, held until acked
//   beat             out  1               current beat index
//   busy             out  1               state is not IDLE
//   done             out  1               access completed (pulse)
//   err_illegal_sel  out  1               select out of range (pulse)
//   err_misalign     out  1               misaligned word address (pulse)
// ---------------------------------------------------------------------------
module mem_addr_sequencer
    import mem_addr_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SRC    = 6,
    parameter int SEL_W      = 3,
    parameter int SWAP_A_IDX = SRC_SWAP1,
    parameter int SWAP_B_IDX = SRC_SWAP2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      swap_mode,
    input  logic                      word_access,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic                      mem_ack,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_req,
    output logic                      beat,
    output logic                      busy,
    output logic                      done,
    output logic                      err_illegal_sel,
    output logic                      err_misalign
);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;
    logic               beat_q, beat_d;
    logic               done_q, done_d;
    logic               err_illegal_q, err_illegal_d;
    logic               err_misalign_q, err_misalign_d;
    logic               swap_q, swap_d;   // swap_mode latched at start
    logic               word_q, word_d;   // word_access latched at start

    // ------------------------------------------------------------------
    // Source select
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]   src_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_oor;

    // In ISSUE the only address ever needed next is swap beat B; in IDLE
    // the swap flag overrides sel so a garbage sel cannot flag an error.
    always_comb begin
        if (state_q == ST_ISSUE) begin
            src_idx = SEL_W'(SWAP_B_IDX);
        end else if (swap_mode) begin
            src_idx = SEL_W'(SWAP_A_IDX);
        end else begin
            src_idx = sel;
        end
    end

    addr_src_select #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_addr_src_select (
        .src_addr     (src_addr),
        .idx          (src_idx),
        .addr         (sel_addr),
        .out_of_range (sel_oor)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        mem_req_d      = mem_req_q;
        beat_d         = beat_q;
        done_d         = 1'b0;
        err_illegal_d  = 1'b0;
        err_misalign_d = 1'b0;
        swap_d         = swap_q;
        word_d         = word_q;

        unique case (state_q)
            ST_IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (start) begin
                    if (sel_oor) begin
                        err_illegal_d = 1'b1;
                    end else if (word_access && is_misaligned(sel_addr[1:0])) begin
                        err_misalign_d = 1'b1;
                    end else begin
                        mem_addr_d = sel_addr;
                        mem_req_d  = 1'b1;
                        beat_d     = 1'b0;
                        swap_d     = swap_mode;
                        word_d     = word_access;
                        state_d    = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                // start is ignored while busy; address and request hold
                // until the beat is acked.
                if (mem_ack) begin
                    if (swap_q && !beat_q) begin
                        // Beat B is sampled in the ack cycle of beat A so
                        // mem_req stays high with no gap between beats.
                        if (word_q && is_misaligned(sel_addr[1:0])) begin
                            err_misalign_d = 1'b1;
                            mem_req_d      = 1'b0;
                            beat_d         = 1'b0;
                            state_d        = ST_IDLE;
                        end else begin
                            mem_addr_d = sel_addr;
                            beat_d     = 1'b1;
                        end
                    end else begin
                        mem_req_d = 1'b0;
                        beat_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                beat_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            mem_addr_q     <= '0;
            mem_req_q      <= 1'b0;
            beat_q         <= 1'b0;
            done_q         <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_misalign_q <= 1'b0;
            swap_q         <= 1'b0;
            word_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_req_q      <= mem_req_d;
            beat_q         <= beat_d;
            done_q         <= done_d;
            err_illegal_q  <= err_illegal_d;
            err_misalign_q <= err_misalign_d;
            swap_q         <= swap_d;
            word_q         <= word_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr        = mem_addr_q;
        mem_req         = mem_req_q;
        beat            = beat_q;
        busy            = (state_q != ST_IDLE);
        done            = done_q;
        err_illegal_sel = err_illegal_q;
        err_misalign    = err_misalign_q;
    end

endmodule : mem_addr_sequencer

// File: tb/tb_mem_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_addr_sequencer
//
// Directed, cycle-by-cycle bench for mem_addr_sequencer. Each step drives
// inputs, pushes the expected output vector
//   {mem_addr, mem_req, beat, busy, done, err_illegal_sel, err_misalign}
// for the following rising edge, then pops and compares it 1 ns after that
// edge.
// ---------------------------------------------------------------------------
module tb_mem_addr_sequencer;

    localparam int ADDR_W  = 32;
    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;
    localparam int VEC_W   = ADDR_W + 6;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic                      start;
    logic [SEL_W-1:0]          sel;
    logic                      swap_mode;
    logic                      word_access;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic                      mem_ack;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_req;
    logic                      beat;
    logic                      busy;
    logic                      done;
    logic                      err_illegal_sel;
    logic                      err_misalign;

    mem_addr_sequencer #(
        .ADDR_W     (ADDR_W),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .SWAP_A_IDX (4),
        .SWAP_B_IDX (5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .sel             (sel),
        .swap_mode       (swap_mode),
        .word_access     (word_access),
        .src_addr        (src_addr),
        .mem_ack         (mem_ack),
        .mem_addr        (mem_addr),
        .mem_req         (mem_req),
        .beat            (beat),
        .busy            (busy),
        .done            (done),
        .err_illegal_sel (err_illegal_sel),
        .err_misalign    (err_misalign)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] exp_q[$];
    int assert_cnt = 0;
    int fail_cnt   = 0;

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_src(input int idx, input logic [ADDR_W-1:0] value);
        src_addr[idx*ADDR_W +: ADDR_W] = value;
    endtask

    task automatic drive(input logic st, input logic [SEL_W-1:0] s,
                         input logic sw, input logic wd, input logic ack);
        start       = st;
        sel         = s;
        swap_mode   = sw;
        word_access = wd;
        mem_ack     = ack;
    endtask

    // Push the expectation for the next edge, clock once, pop and compare.
    task automatic step(input string tag, input logic [ADDR_W-1:0] e_addr,
                        input logic e_req, input logic e_beat, input logic e_busy,
                        input logic e_done, input logic e_ill, input logic e_mis);
        logic [VEC_W-1:0] obs;
        logic [VEC_W-1:0] exp_v;
        exp_q.push_back({e_addr, e_req, e_beat, e_busy, e_done, e_ill, e_mis});
        @(posedge clk);
        #1;
        obs   = {mem_addr, mem_req, beat, busy, done, err_illegal_sel, err_misalign};
        exp_v = exp_q.pop_front();
        assert_cnt++;
        assert (obs === exp_v) else begin
            fail_cnt++;
            $error("FAIL %s: observed addr=%h req/beat/busy/done/ill/mis=%b expected addr=%h req/beat/busy/done/ill/mis=%b",
                   tag, obs[VEC_W-1:6], obs[5:0], exp_v[VEC_W-1:6], exp_v[5:0]);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        src_addr = '0;
        set_src(0, 32'h0000_0006);
        set_src(1, 32'h0000_0080);
        set_src(2, 32'h0000_0040);
        set_src(3, 32'h0000_1234);
        set_src(4, 32'h0000_0100);
        set_src(5, 32'h0000_0200);

        // Reset held with start asserted: everything stays 0.
        reset_n = 1'b0;
        drive(1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        step("rst_0", 32'h0, 0, 0, 0, 0, 0, 0);
        step("rst_1", 32'h0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("idle_after_rst", 32'h0, 0, 0, 0, 0, 0, 0);

        // Single word access from ALUOut, ack on the first req cycle.
        drive(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        step("single_req", 32'h40, 1, 0, 1, 0, 0, 0);
        // start while busy (sel=3) must be ignored.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        step("single_done", 32'h40, 0, 0, 0, 1, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("single_idle", 32'h40, 0, 0, 0, 0, 0, 0);

        // Swap, acks delayed two cycles per beat; sel=7 ignored in swap mode.
        drive(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        step("swap_a_c1", 32'h100, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("swap_a_c2", 32'h100, 1, 0, 1, 0, 0, 0);
        step("swap_a_c3", 32'h100, 1, 0, 1, 0, 0, 0);
        mem_ack = 1'b1;
        step("swap_b_c1", 32'h200, 1, 1, 1, 0, 0, 0);
        mem_ack = 1'b0;
        step("swap_b_c2", 32'h200, 1, 1, 1, 0, 0, 0);
        step("swap_b_c3", 32'h200, 1, 1, 1, 0, 0, 0);
        mem_ack = 1'b1;
        step("swap_done", 32'h200, 0, 0, 0, 1, 0, 0);
        // Ack in IDLE is ignored.
        step("ack_in_idle", 32'h200, 0, 0, 0, 0, 0, 0);

        // Illegal selects: 7 and the boundary value 6.
        drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        step("illegal_sel7", 32'h200, 0, 0, 0, 0, 1, 0);
        drive(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
        step("illegal_sel6", 32'h200, 0, 0, 0, 0, 1, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("illegal_clr", 32'h200, 0, 0, 0, 0, 0, 0);

        // Misaligned word access from PC: no request.
        drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        step("misalign_word", 32'h200, 0, 0, 0, 0, 0, 1);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step("misalign_clr", 32'h200, 0, 0, 0, 0, 0, 0);

        // Same address as a byte access: accepted. Ack in the start cycle
        // is ignored, the next ack completes it.
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        step("byte_req", 32'h6, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("byte_done", 32'h6, 0, 0, 0, 1, 0, 0);
        mem_ack = 1'b0;

        // Swap with misaligned beat B under word access: error, no done.
        set_src(5, 32'h0000_0202);
        drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        step("swapmis_a", 32'h100, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("swapmis_err", 32'h100, 0, 0, 0, 0, 0, 1);
        mem_ack = 1'b0;
        step("swapmis_idle", 32'h100, 0, 0, 0, 0, 0, 0);

        // Swap with immediate acks: done 3 cycles after start. Swap flags
        // latched at start must ignore later changes on swap_mode/word_access.
        set_src(5, 32'h0000_0200);
        drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        step("swapfast_a", 32'h100, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step("swapfast_b", 32'h200, 1, 1, 1, 0, 0, 0);
        step("swapfast_done", 32'h200, 0, 0, 0, 1, 0, 0);
        mem_ack = 1'b0;

        // Reset during swap beat 1 aborts without done.
        set_src(5, 32'h0000_0300);
        drive(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        step("abort_a", 32'h100, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("abort_b", 32'h300, 1, 1, 1, 0, 0, 0);
        reset_n = 1'b1;
        reset_n = 1'b0;
        mem_ack = 1'b0;
        step("abort_rst", 32'h0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        // New single access right after release; one ack must finish it,
        // proving the latched swap flag was cleared.
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("post_rst_req", 32'h1234, 1, 0, 1, 0, 0, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("post_rst_done", 32'h1234, 0, 0, 0, 1, 0, 0);
        mem_ack = 1'b0;
        step("final_idle", 32'h1234, 0, 0, 0, 0, 0, 0);

        // Every pushed expectation must have been consumed.
        assert_cnt++;
        assert (exp_q.size() == 0) else begin
            fail_cnt++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_mem_addr_sequencer
